// File: rtl/la_invpipe.sv
// Registered per-bit inverter carried through a DEPTH-stage valid/ready pipeline.
// Empty stages are always refilled, so the pipe stores up to DEPTH words under backpressure.
module la_invpipe #(
  parameter     PROP  = "DEFAULT",
  parameter int DW    = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inv,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  input  logic          flush
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [DEPTH-1:0] v_s;
  logic [DW-1:0]    d_s [DEPTH];
  logic [DEPTH-1:0] adv_s;
  logic             full_above_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;

  // Advance chain: stage i may load when any stage at or beyond it is empty, or the sink takes a word.
  always_comb begin
    adv_s        = '0;
    full_above_s = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full_above_s = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        full_above_s = full_above_s & v_s[j];
      end
      adv_s[i] = out_ready | ~full_above_s;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic          v_r;
    logic [DW-1:0] d_r;
    logic          src_v_s;
    logic [DW-1:0] src_d_s;

    if (g == 0) begin : g_head
      assign src_v_s = in_valid;
      assign src_d_s = in_data ^ inv;
    end else begin : g_body
      assign src_v_s = v_s[g-1];
      assign src_d_s = d_s[g-1];
    end

    // Stage register: load from upstream when advancing; flush drops the valid only.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        d_r <= '0;
      end else begin
        if (adv_s[g]) begin
          d_r <= src_d_s;
        end
        if (flush) begin
          v_r <= 1'b0;
        end else if (adv_s[g]) begin
          v_r <= src_v_s;
        end
      end
    end

    assign v_s[g] = v_r;
    assign d_s[g] = d_r;
  end

  // Occupancy bookkeeping from the two handshakes.
  always_comb begin
    in_xfer_s    = in_valid & adv_s[0];
    out_xfer_s   = v_s[DEPTH-1] & out_ready;
    count_next_s = count_r;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Occupancy register; flush empties the pipe together with the stage valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = v_s[DEPTH-1];
  assign out_data  = d_s[DEPTH-1];
  assign count     = count_r;

endmodule

// File: tb/tb_la_invpipe.sv
// Self-checking bench for la_invpipe: a queue model of in-flight words plus literal spot checks.
module tb_la_invpipe;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] inv;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          flush;

  la_invpipe #(.PROP("DEFAULT"), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .inv(inv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: words in flight, oldest first, each tagged with the stage it occupies.
  typedef struct {
    logic [DW-1:0] d;
    int            pos;
  } word_t;
  word_t mq[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_ready();
    return (mq.size() < DEPTH) || out_ready;
  endfunction

  function automatic logic m_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  task automatic compare_model();
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid()));
    chk("count", 32'(count), 32'(mq.size()));
    if (m_valid()) chk("out_data", 32'(out_data), 32'(mq[0].d));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic rdy;
    int   lim;
    int   np;
    rdy = m_ready();
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (m_valid() && out_ready) void'(mq.pop_front());
      lim = DEPTH;
      for (int i = 0; i < mq.size(); i++) begin
        np = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
        mq[i].pos = np;
        lim = np;
      end
      if (in_valid && rdy) begin
        word_t w;
        w.d   = in_data ^ inv;
        w.pos = 0;
        mq.push_back(w);
      end
    end
  endtask

  // One cycle: drive inputs, check the visible state against the model, then step the model.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic [DW-1:0] iinv,
                     input logic ordy, input logic fl, input logic r);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    inv       = iinv;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    compare_model();
    model_step();
  endtask

  task automatic lit(input string name, input logic ev, input logic [DW-1:0] ed,
                     input int ec, input logic er);
    chk({name, "_valid"}, 32'(out_valid), 32'(ev));
    chk({name, "_count"}, 32'(count), 32'(ec));
    chk({name, "_ready"}, 32'(in_ready), 32'(er));
    if (ev) chk({name, "_data"}, 32'(out_data), 32'(ed));
  endtask

  initial begin
    logic [47:0] iv_pat;
    logic [47:0] or_pat;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; inv = 8'hFF; out_ready = 1'b1;

    // Reset, then stream with full inversion.
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("reset", 1'b0, 8'h00, 0, 1'b1);
    chk("reset_data", 32'(out_data), 32'h0);
    cyc(1'b1, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t1_w0", 1'b1, 8'hFF, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t1_w1", 1'b1, 8'hA5, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t1_w2", 1'b1, 8'h0F, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Polarity sampled at acceptance.
    cyc(1'b1, 8'hAA, 8'h0F, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t2_w0", 1'b1, 8'hA5, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t2_w1", 1'b1, 8'hAA, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Backpressure fill, then one drain cycle with simultaneous accept.
    cyc(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t3_full", 1'b1, 8'hFE, 2, 1'b0);
    cyc(1'b1, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t3_hold", 1'b1, 8'hFE, 2, 1'b0);
    cyc(1'b1, 8'h03, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t3_drain", 1'b1, 8'hFE, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t3_after", 1'b1, 8'hFD, 2, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t3_last", 1'b1, 8'hFC, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Bubble collapse under stall.
    cyc(1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t4_collapse", 1'b1, 8'hEF, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t4_stall", 1'b1, 8'hEF, 2, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t4_order", 1'b1, 8'hDF, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Flush of a full pipe while a word is accepted the same cycle.
    cyc(1'b1, 8'h31, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 8'hFF, 1'b1, 1'b1, 1'b0);
    lit("t5_pre", 1'b1, 8'hCE, 2, 1'b1);
    cyc(1'b1, 8'h40, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t5_flushed", 1'b0, 8'h00, 0, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t5_lat", 1'b1, 8'hBF, 1, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream, alone and together with flush.
    cyc(1'b1, 8'h50, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h51, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h52, 8'hFF, 1'b1, 1'b0, 1'b1);
    lit("t6_pre", 1'b1, 8'hAF, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t6_rst", 1'b0, 8'h00, 0, 1'b1);
    chk("t6_rst_data", 32'(out_data), 32'h0);
    cyc(1'b1, 8'h60, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h61, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 8'hFF, 1'b1, 1'b1, 1'b1);
    lit("t6_pre2", 1'b1, 8'h9F, 2, 1'b1);
    cyc(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    lit("t6_rstfl", 1'b0, 8'h00, 0, 1'b1);
    chk("t6_rstfl_data", 32'(out_data), 32'h0);

    // Mixed traffic pattern checked against the model only.
    iv_pat = 48'hB6D5_A93C_F0E1;
    or_pat = 48'h9C3A_57E2_6D1B;
    for (int k = 0; k < 48; k++) begin
      cyc(iv_pat[k], 8'(k * 37 + 3), 8'(k * 11), or_pat[k], (k == 30) ? 1'b1 : 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
